capi_cmd_arbiter: RTL and testbench
===================================

// Module: capi_cmd_arbiter
// PURPOSE
//  Multi-channel PSL command issuer. Arbitrates N_CHANNELS AFU requestors onto the single
//  PSL command interface, allocates tags, tracks PSL command credits, generates odd parity,
//  and routes PSL responses back to the owning channel by tag. Sits between AFU engines and the PSL.
// PARAMETERS
//  N_CHANNELS  4    number of requesting engines (1..16)
//  N_TAGS      32   outstanding-tag pool size (1..256); tags issued are 0..N_TAGS-1
//  CH_W        $clog2(N_CHANNELS) (min 1), derived; owner-id width
// PORTS
//  clock        in   1            PSL clock
//  reset_n      in   1            async active-low reset
//  req_valid    in   N_CHANNELS   per-channel request valid
//  req_ready    out  N_CHANNELS   per-channel accept (valid&ready = handshake)
//  req_command  in   N_CH*13      afu_command_t per channel, channel 0 in LSBs
//  req_address  in   N_CH*64      pointer_t per channel
//  req_size     in   N_CH*12      byte size per channel
//  ctx_handle   in   16           context handle for all commands
//  cmd_in       in   CommandInterfaceInput   PSL room
//  cmd_out      out  CommandInterfaceOutput  registered PSL command bus
//  rsp_in       in   ResponseInterface       PSL response bus
//  rsp_valid    out  N_CHANNELS   one-hot: response belongs to channel i
//  rsp_tag      out  8            response tag (broadcast)
//  rsp_code     out  8            response code (broadcast)
//  drain        in   1            stop granting new requests
//  idle         out  1            drain asserted and zero tags outstanding
//  credits      out  8            current available credits
//  tag_error    out  1            sticky: response for non-outstanding tag or bad tag parity
// BEHAVIOUR
//  Reset: FSM=LOAD; cmd_out all zero (valid=0); req_ready=0; rsp_valid=0; credits=0;
//   tag_error=0; idle=0; all tags free; round-robin pointer=0.
//  FSM LOAD: one cycle after reset release, credits<=cmd_in.room; -> RUN. No grants in LOAD.
//  FSM RUN: grant allowed when !drain, credits>0, free tag exists.
//  Arbitration: round-robin starting at ptr; winner w gets req_ready[w]=1 (combinational,
//   at most one bit); after a grant ptr<=w+1 mod N_CHANNELS; no grant -> ptr unchanged.
//  Issue latency: handshake in cycle t -> cmd_out.valid=1 in t+1 for exactly one cycle.
//  Tag: lowest-numbered free tag; marked busy, owner[tag]<=w. abt=0, context_handle=ctx_handle.
//  Parity (odd): tag_parity=~^tag, command_parity=~^command, address_parity=~^address.
//  Response: rsp_in.valid with tag<N_TAGS, tag busy, parity ok -> next cycle rsp_valid[owner]=1,
//   rsp_tag/rsp_code registered; tag freed (reusable from cycle after response, never same cycle).
//   Otherwise tag_error<=1 (sticky until reset), no routing, no free.
//  Credits: next = credits - grant + (rsp valid ? signed rsp_in.credits : 0); saturate 0..255.
//   Simultaneous grant and response in one cycle both apply.
//  Full: no free tag or credits==0 -> req_ready=0 all channels; requests wait, valid holds.
//  drain: blocks grants from the same cycle; outstanding responses still routed;
//   idle=1 when drain && RUN && no busy tags. Deasserting drain resumes immediately.
//  reset_n low mid-operation: all tags freed, outstanding commands discarded, back to LOAD.
// STRUCTURE
//  Package CAPI: afu_command_t, CommandInterfaceInput/Output, ResponseInterface (existing);
//   add parity function odd_parity and localparam ABT_STRICT=3'b000.
//  Sub-module capi_tag_pool: free bitmap, lowest-free encoder, alloc/free ports, owner RAM,
//   busy lookup; arbiter/credit/FSM logic in this module.
// TESTING
//  1 Reset, room=8, ch0 single READ_CL_NA addr 0x1000 -> cmd_out.valid 2nd cycle after LOAD,
//    tag 0, tag_parity=1, credits 8->7.
//  2 All 4 channels valid continuously -> grants 0,1,2,3,0 in consecutive cycles, tags 0..4.
//  3 N_TAGS=4, room=16, no responses -> 4 issues then req_ready=0; response tag 2 credits=+1
//    -> rsp_valid[owner of 2]=1, next grant gets tag 2.
//  4 room=2, two issues -> credits 0, stall; response credits=+1 same cycle as pending req
//    -> grant only after credits=1 registered.
//  5 Response tag 7 never issued -> tag_error=1 stays set, rsp_valid stays 0, credits updated.
//  6 drain with 3 outstanding -> no grants, idle=0 until 3rd response, then idle=1; reset_n
//    pulse mid-burst -> cmd_out.valid=0, all tags free, LOAD re-samples room.

Source files
------------

// File: rtl/capi_cmd_arbiter_pkg.sv
// Shared PSL command/response types and helpers for the CAPI command arbiter.
package capi_cmd_arbiter_pkg;

  typedef enum logic [12:0] {
    READ_CL_NA = 13'h0A00,
    READ_CL_S  = 13'h0A50,
    READ_CL_M  = 13'h0A60,
    READ_PNA   = 13'h0E00,
    WRITE_NA   = 13'h0D00,
    WRITE_MI   = 13'h0D60,
    TOUCH_I    = 13'h0240
  } afu_command_t;

  typedef logic [63:0] pointer_t;

  typedef struct packed {
    logic [7:0] room;
  } CommandInterfaceInput;

  typedef struct packed {
    logic         valid;
    logic [7:0]   tag;
    logic         tag_parity;
    afu_command_t command;
    logic         command_parity;
    logic [2:0]   abt;
    pointer_t     address;
    logic         address_parity;
    logic [15:0]  context_handle;
    logic [11:0]  size;
  } CommandInterfaceOutput;

  typedef struct packed {
    logic              valid;
    logic [7:0]        tag;
    logic              tag_parity;
    logic [7:0]        response;
    logic signed [8:0] credits;
  } ResponseInterface;

  localparam logic [2:0] ABT_STRICT = 3'b000;

  // Zero-extension does not change the XOR, so one width serves every field.
  function automatic logic odd_parity(input logic [63:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/capi_tag_pool.sv
// Outstanding-tag pool: free bitmap, lowest-free allocation, owner table and busy lookup.
module capi_tag_pool #(
  parameter int unsigned N_TAGS = 32,
  parameter int unsigned CH_W   = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alloc,
  input  logic [CH_W-1:0] alloc_owner,
  output logic [7:0]      alloc_tag,
  output logic            free_avail,
  input  logic            release_en,
  input  logic [7:0]      release_tag,
  input  logic [7:0]      lookup_tag,
  output logic            lookup_busy,
  output logic [CH_W-1:0] lookup_owner,
  output logic            any_busy
);

  logic [N_TAGS-1:0] busy_q, busy_d;
  logic [CH_W-1:0]   owner_q [N_TAGS];

  always_comb begin
    alloc_tag  = '0;
    free_avail = 1'b0;
    for (int i = 0; i < N_TAGS; i++) begin
      if (!busy_q[i] && !free_avail) begin
        alloc_tag  = 8'(i);
        free_avail = 1'b1;
      end
    end
  end

  // Tags at or above N_TAGS never match, so they read back as not busy.
  always_comb begin
    lookup_busy  = 1'b0;
    lookup_owner = '0;
    for (int i = 0; i < N_TAGS; i++) begin
      if (lookup_tag == 8'(i)) begin
        lookup_busy  = busy_q[i];
        lookup_owner = owner_q[i];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < N_TAGS; i++) begin
      if (release_en && release_tag == 8'(i)) busy_d[i] = 1'b0;
      if (alloc && alloc_tag == 8'(i))        busy_d[i] = 1'b1;
    end
  end

  assign any_busy = |busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_TAGS; i++) begin
      if (alloc && alloc_tag == 8'(i)) owner_q[i] <= alloc_owner;
    end
  end

endmodule

// File: rtl/capi_cmd_arbiter.sv
// Round-robin PSL command issuer: grants AFU channels, allocates tags, tracks credits,
// and routes PSL responses back to the channel that owns each tag.
module capi_cmd_arbiter import capi_cmd_arbiter_pkg::*; #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned N_TAGS     = 32,
  parameter int unsigned CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_CHANNELS-1:0]    req_valid,
  output logic [N_CHANNELS-1:0]    req_ready,
  input  logic [N_CHANNELS*13-1:0] req_command,
  input  logic [N_CHANNELS*64-1:0] req_address,
  input  logic [N_CHANNELS*12-1:0] req_size,
  input  logic [15:0]              ctx_handle,
  input  CommandInterfaceInput     cmd_in,
  output CommandInterfaceOutput    cmd_out,
  input  ResponseInterface         rsp_in,
  output logic [N_CHANNELS-1:0]    rsp_valid,
  output logic [7:0]               rsp_tag,
  output logic [7:0]               rsp_code,
  input  logic                     drain,
  output logic                     idle,
  output logic [7:0]               credits,
  output logic                     tag_error
);

  localparam logic [0:0] StLoad = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [7:0]            credits_q, credits_d;
  logic [CH_W-1:0]       ptr_q, ptr_d, ptr_inc, win, lookup_owner;
  CommandInterfaceOutput cmd_q, cmd_d;
  logic [N_CHANNELS-1:0] rsp_valid_q, rsp_valid_d, rot;
  logic [7:0]            rsp_tag_q, rsp_code_q, alloc_tag;
  logic                  tag_error_q, found, grant, free_avail, lookup_busy, any_busy, rsp_ok;
  logic [12:0]           sel_cmd;
  logic [63:0]           sel_addr;
  logic [11:0]           sel_size;

  capi_tag_pool #(
    .N_TAGS (N_TAGS),
    .CH_W   (CH_W)
  ) u_tag_pool (
    .clock        (clock),
    .reset_n      (reset_n),
    .alloc        (grant),
    .alloc_owner  (win),
    .alloc_tag    (alloc_tag),
    .free_avail   (free_avail),
    .release_en   (rsp_ok),
    .release_tag  (rsp_in.tag),
    .lookup_tag   (rsp_in.tag),
    .lookup_busy  (lookup_busy),
    .lookup_owner (lookup_owner),
    .any_busy     (any_busy)
  );

  // Rotate so bit 0 is the channel at the round-robin pointer.
  assign rot = N_CHANNELS'({req_valid, req_valid} >> ptr_q);

  always_comb begin
    int unsigned s;
    int unsigned n;
    found = 1'b0;
    win   = '0;
    s     = 0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        s     = 32'(ptr_q) + 32'(k);
        if (s >= N_CHANNELS) s = s - N_CHANNELS;
        win = CH_W'(s);
      end
    end
    n = 32'(win) + 1;
    if (n >= N_CHANNELS) n = 0;
    ptr_inc = CH_W'(n);
  end

  assign grant = found && (state_q == StRun) && !drain && (credits_q != 8'd0) && free_avail;
  assign ptr_d = grant ? ptr_inc : ptr_q;

  always_comb begin
    req_ready = '0;
    sel_cmd   = '0;
    sel_addr  = '0;
    sel_size  = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (win == CH_W'(i)) begin
        req_ready[i] = grant;
        sel_cmd      = req_command[i*13 +: 13];
        sel_addr     = req_address[i*64 +: 64];
        sel_size     = req_size[i*12 +: 12];
      end
    end
  end

  always_comb begin
    cmd_d = '0;
    if (grant) begin
      cmd_d.valid          = 1'b1;
      cmd_d.tag            = alloc_tag;
      cmd_d.tag_parity     = odd_parity(64'(alloc_tag));
      cmd_d.command        = afu_command_t'(sel_cmd);
      cmd_d.command_parity = odd_parity(64'(sel_cmd));
      cmd_d.abt            = ABT_STRICT;
      cmd_d.address        = sel_addr;
      cmd_d.address_parity = odd_parity(sel_addr);
      cmd_d.context_handle = ctx_handle;
      cmd_d.size           = sel_size;
    end
  end

  assign rsp_ok = rsp_in.valid && lookup_busy &&
                  (rsp_in.tag_parity == odd_parity(64'(rsp_in.tag)));

  always_comb begin
    for (int i = 0; i < N_CHANNELS; i++) begin
      rsp_valid_d[i] = rsp_ok && (lookup_owner == CH_W'(i));
    end
  end

  // Credits move by -grant plus the signed PSL return; clamp to the 8-bit counter range.
  always_comb begin
    int c;
    state_d   = state_q;
    credits_d = credits_q;
    c         = int'(credits_q) - (grant ? 1 : 0) +
                (rsp_in.valid ? int'($signed(rsp_in.credits)) : 0);
    if (c < 0)   c = 0;
    if (c > 255) c = 255;
    if (state_q == StLoad) begin
      state_d   = StRun;
      credits_d = cmd_in.room;
    end else begin
      credits_d = 8'(c);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StLoad;
      credits_q   <= '0;
      ptr_q       <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
      rsp_code_q  <= '0;
      tag_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      if (rsp_ok) begin
        rsp_tag_q  <= rsp_in.tag;
        rsp_code_q <= rsp_in.response;
      end
      if (rsp_in.valid && !rsp_ok) tag_error_q <= 1'b1;
    end
  end

  assign cmd_out   = cmd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_code  = rsp_code_q;
  assign credits   = credits_q;
  assign tag_error = tag_error_q;
  assign idle      = drain && (state_q == StRun) && !any_busy;

endmodule

// File: tb/tb_capi_cmd_arbiter.sv
// Randomized scoreboard bench for capi_cmd_arbiter against a transaction-level model.
module tb_capi_cmd_arbiter;
  import capi_cmd_arbiter_pkg::*;

  localparam int NCH = 4;
  localparam int NT  = 8;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NCH-1:0]        req_valid = '0, req_ready;
  logic [NCH*13-1:0]     req_command = '0;
  logic [NCH*64-1:0]     req_address = '0;
  logic [NCH*12-1:0]     req_size = '0;
  logic [15:0]           ctx_handle = '0;
  CommandInterfaceInput  cmd_in = '0;
  CommandInterfaceOutput cmd_out;
  ResponseInterface      rsp_in = '0;
  logic [NCH-1:0]        rsp_valid;
  logic [7:0]            rsp_tag, rsp_code, credits;
  logic                  drain = 1'b0, idle, tag_error;

  always #5 clock = ~clock;

  capi_cmd_arbiter #(
    .N_CHANNELS (NCH),
    .N_TAGS     (NT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_command (req_command),
    .req_address (req_address),
    .req_size    (req_size),
    .ctx_handle  (ctx_handle),
    .cmd_in      (cmd_in),
    .cmd_out     (cmd_out),
    .rsp_in      (rsp_in),
    .rsp_valid   (rsp_valid),
    .rsp_tag     (rsp_tag),
    .rsp_code    (rsp_code),
    .drain       (drain),
    .idle        (idle),
    .credits     (credits),
    .tag_error   (tag_error)
  );

  typedef struct {
    logic [7:0]  tag;
    logic        tpar;
    logic [12:0] cmd;
    logic        cpar;
    logic [63:0] addr;
    logic        apar;
    logic [15:0] ctx;
    logic [11:0] size;
  } exp_cmd_t;

  typedef struct {
    logic [NCH-1:0] onehot;
    logic [7:0]     tag;
    logic [7:0]     code;
  } exp_rsp_t;

  exp_cmd_t exp_cmd[$];
  exp_rsp_t exp_rsp[$];

  int total = 0;
  int bad   = 0;

  // Model state: which tags are out, who owns them, credit count, next channel in turn.
  bit          busy_m [NT];
  int          owner_m[NT];
  int          credits_m;
  int          ptr_m;
  bit          terr_m;
  bit          pending[NCH];
  logic [12:0] pcmd[NCH];
  logic [63:0] paddr[NCH];
  logic [11:0] psize[NCH];
  logic [12:0] cmd_list[4];

  int p_req = 0, p_rsp = 0, p_drain = 0, p_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit par(input logic [63:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic int outstanding();
    int n = 0;
    for (int i = 0; i < NT; i++) n += busy_m[i];
    return n;
  endfunction

  task automatic drive_reqs();
    for (int ch = 0; ch < NCH; ch++) begin
      req_valid[ch]             = pending[ch];
      req_command[ch*13 +: 13]  = pcmd[ch];
      req_address[ch*64 +: 64]  = paddr[ch];
      req_size[ch*12 +: 12]     = psize[ch];
    end
  endtask

  task automatic step();
    int       w, t, delta, q[$];
    bit       rv, rok;
    logic [7:0] tg;
    logic [NCH-1:0] exp_ready;
    @(negedge clock);
    cmd_in.room = 8'($urandom);
    for (int ch = 0; ch < NCH; ch++) begin
      if (!pending[ch] && $urandom_range(99) < p_req) begin
        pending[ch] = 1'b1;
        pcmd[ch]    = cmd_list[$urandom_range(3)];
        paddr[ch]   = {$urandom, $urandom};
        psize[ch]   = 12'($urandom);
      end
    end
    drive_reqs();
    ctx_handle = 16'($urandom);
    drain      = ($urandom_range(99) < p_drain);
    rsp_in     = '0;
    rv         = 1'b0;
    tg         = '0;
    delta      = 0;
    if ($urandom_range(99) < p_rsp) begin
      if ($urandom_range(99) < p_err) begin
        tg = 8'($urandom_range(255));
        rsp_in.tag_parity = 1'($urandom);
        rv = 1'b1;
      end else begin
        for (int i = 0; i < NT; i++) if (busy_m[i]) q.push_back(i);
        if (q.size() > 0) begin
          tg = 8'(q[$urandom_range(q.size() - 1)]);
          rsp_in.tag_parity = par(64'(tg));
          rv = 1'b1;
        end
      end
      if (rv) begin
        delta           = int'($urandom_range(3)) - 1;
        rsp_in.valid    = 1'b1;
        rsp_in.tag      = tg;
        rsp_in.response = 8'($urandom);
        rsp_in.credits  = 9'(delta);
      end
    end
    #1;
    chk("credits", credits, 64'(credits_m));
    chk("idle", idle, drain && outstanding() == 0);
    chk("tag_error", tag_error, terr_m);
    rok = 1'b0;
    if (rv && tg < NT) rok = busy_m[tg] && (rsp_in.tag_parity == par(64'(tg)));
    w = -1;
    if (!drain && credits_m > 0 && outstanding() < NT) begin
      for (int k = 0; k < NCH; k++) begin
        if (w < 0 && pending[(ptr_m + k) % NCH]) w = (ptr_m + k) % NCH;
      end
    end
    exp_ready = (w >= 0) ? NCH'(1 << w) : '0;
    chk("req_ready", req_ready, exp_ready);
    if (w >= 0) begin
      t = 0;
      while (busy_m[t]) t++;
      exp_cmd.push_back('{tag: 8'(t), tpar: par(64'(t)), cmd: pcmd[w], cpar: par(64'(pcmd[w])),
                          addr: paddr[w], apar: par(paddr[w]), ctx: ctx_handle, size: psize[w]});
      busy_m[t]   = 1'b1;
      owner_m[t]  = w;
      pending[w]  = 1'b0;
      ptr_m       = (w + 1) % NCH;
    end
    if (rv) begin
      if (rok) begin
        exp_rsp.push_back('{onehot: NCH'(1 << owner_m[tg]), tag: tg, code: rsp_in.response});
        busy_m[tg] = 1'b0;
      end else begin
        terr_m = 1'b1;
      end
    end
    credits_m = credits_m - ((w >= 0) ? 1 : 0) + delta;
    if (credits_m < 0)   credits_m = 0;
    if (credits_m > 255) credits_m = 255;
  endtask

  task automatic do_reset(input int room);
    @(negedge clock);
    reset_n     = 1'b0;
    cmd_in.room = 8'(room);
    rsp_in      = '0;
    drain       = 1'b0;
    #1;
    chk("rst_cmd_valid", cmd_out.valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_credits", credits, 0);
    chk("rst_tag_error", tag_error, 0);
    chk("rst_idle", idle, 0);
    for (int i = 0; i < NT; i++) busy_m[i] = 1'b0;
    ptr_m  = 0;
    terr_m = 1'b0;
    exp_cmd.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("load_req_ready", req_ready, 0);
    chk("load_credits", credits, 0);
    credits_m = room;
  endtask

  // Monitor: every scoreboard entry must show up exactly one edge after its push.
  initial begin
    exp_cmd_t ec;
    exp_rsp_t er;
    forever begin
      @(posedge clock);
      #1;
      if (cmd_out.valid) begin
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", cmd_out.valid, 0);
        end else begin
          ec = exp_cmd.pop_front();
          chk("cmd_tag", cmd_out.tag, ec.tag);
          chk("cmd_tag_parity", cmd_out.tag_parity, ec.tpar);
          chk("cmd_command", cmd_out.command, ec.cmd);
          chk("cmd_command_parity", cmd_out.command_parity, ec.cpar);
          chk("cmd_address", cmd_out.address, ec.addr);
          chk("cmd_address_parity", cmd_out.address_parity, ec.apar);
          chk("cmd_abt", cmd_out.abt, 0);
          chk("cmd_ctx", cmd_out.context_handle, ec.ctx);
          chk("cmd_size", cmd_out.size, ec.size);
        end
      end else if (exp_cmd.size() != 0) begin
        chk("cmd_missing", cmd_out.valid, 1);
        exp_cmd.delete();
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          er = exp_rsp.pop_front();
          chk("rsp_valid", rsp_valid, er.onehot);
          chk("rsp_tag", rsp_tag, er.tag);
          chk("rsp_code", rsp_code, er.code);
        end
      end else if (exp_rsp.size() != 0) begin
        chk("rsp_missing", rsp_valid, exp_rsp[0].onehot);
        exp_rsp.delete();
      end
    end
  end

  initial begin
    cmd_list = '{13'h0A00, 13'h0A50, 13'h0D00, 13'h0240};
    for (int ch = 0; ch < NCH; ch++) begin
      pending[ch] = 1'b0;
      pcmd[ch]    = '0;
      paddr[ch]   = '0;
      psize[ch]   = '0;
    end

    // Single READ_CL_NA on channel 0 with room=8.
    do_reset(8);
    pending[0] = 1'b1;
    pcmd[0]    = 13'h0A00;
    paddr[0]   = 64'h1000;
    psize[0]   = 12'd128;
    repeat (4) step();

    // All channels requesting: rotation 0,1,2,3,0 then tag exhaustion, then responses.
    do_reset(200);
    p_req = 100;
    repeat (12) step();
    p_rsp = 60;
    repeat (60) step();

    // Credit exhaustion with room=2, then credits returned.
    do_reset(2);
    p_rsp = 0;
    repeat (6) step();
    p_rsp = 100;
    repeat (20) step();

    // Random mix with occasional drain.
    do_reset($urandom_range(1, 255));
    p_req = 50; p_rsp = 40; p_drain = 10;
    repeat (1500) step();

    // Hold drain while responses retire the outstanding tags.
    p_drain = 100; p_rsp = 30;
    repeat (60) step();

    // Reset in the middle of a burst, then resume.
    p_drain = 0; p_req = 80; p_rsp = 20;
    repeat (20) step();
    do_reset($urandom_range(1, 255));
    p_req = 50; p_rsp = 40; p_drain = 10;
    repeat (500) step();

    // Bad tags and bad parity.
    p_err = 25;
    repeat (200) step();

    // Retire everything.
    p_err = 0; p_req = 0; p_drain = 100; p_rsp = 100;
    repeat (60) step();
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
